display_page_sequencer: RTL and testbench

- Registered, time-multiplexed successor to the combinational display selector.
- Snapshots game values on a strobe and selects a display page from the game state.
- In result states it auto-rotates pages or blinks the result, and drives a parametrised-width nibble bus to the 7-segment decoder/scanner.

---
 rtl/display_page_sequencer.sv | 169 ++++++++++++++++
 tb/tb_display_page_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_page_sequencer.sv
// Purpose: snapshots game values and drives a paged, rotating or blinking nibble bus to the 7-seg scanner.
// Latency: fixed 2 cycles from any input (value, snap_en or state) to out/page/blank.
// Backpressure: none; free-running, outputs are registered every cycle.
module display_page_sequencer #(
  parameter int DIGITS       = 4,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            state,
  input  logic                  snap_en,
  input  logic [3:0]            round,
  input  logic [3:0]            win,
  input  logic [3:0]            lose,
  input  logic [3:0]            p1_black,
  input  logic [3:0]            p1_white,
  input  logic [3:0]            p2_black,
  input  logic [3:0]            p2_white,
  input  logic [1:0]            gameresult,
  input  logic [1:0]            matchresult,
  output logic [4*DIGITS-1:0]   out,
  output logic [1:0]            page,
  output logic                  blank
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int BW = $clog2(BLINK_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_P1    = 3'd1,
    ST_P2    = 3'd2,
    ST_ROUND = 3'd3,
    ST_MATCH = 3'd4,
    ST_RSV5  = 3'd5,
    ST_RSV6  = 3'd6,
    ST_RSV7  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PG_INFO = 2'd0,
    PG_P1   = 2'd1,
    PG_P2   = 2'd2,
    PG_RES  = 2'd3
  } page_e;

  typedef struct packed {
    logic [3:0] round;
    logic [3:0] win;
    logic [3:0] lose;
    logic [3:0] p1_black;
    logic [3:0] p1_white;
    logic [3:0] p2_black;
    logic [3:0] p2_white;
    logic [1:0] gameresult;
    logic [1:0] matchresult;
  } snap_t;

  // Stage 1 state
  snap_t   snap_q, snap_d;
  state_e  state_q, state_d;
  // Stage 2 state
  state_e  state_prev_q, state_prev_d;
  page_e   page_q, page_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic    phase_q, phase_d;
  logic [4*DIGITS-1:0] out_q, out_d;
  logic    blank_q, blank_d;
  logic    mode_chg;
  logic [15:0] digits_lo;

  // Stage 1: capture values on strobe, always register the game state.
  always_comb begin
    snap_d = snap_q;
    if (snap_en) begin
      snap_d = {round, win, lose, p1_black, p1_white, p2_black, p2_white, gameresult, matchresult};
    end
    state_d = state_e'(state);
  end

  // Stage 2: page selection, rotation and blink timing; a mode change restarts everything.
  always_comb begin
    mode_chg     = (state_q != state_prev_q);
    state_prev_d = state_q;
    page_d       = page_q;
    hold_cnt_d   = '0;
    blink_cnt_d  = '0;
    phase_d      = 1'b0;
    case (state_q)
      ST_P1: page_d = PG_P1;
      ST_P2: page_d = PG_P2;
      ST_ROUND: begin
        if (mode_chg) begin
          page_d = PG_RES;
        end else if (hold_cnt_q == HOLD_MAX) begin
          case (page_q)
            PG_RES:  page_d = PG_P1;
            PG_P1:   page_d = PG_P2;
            default: page_d = PG_RES;
          endcase
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_MATCH: begin
        page_d = PG_RES;
        if (mode_chg) begin
          phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_MAX) begin
          phase_d = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
          phase_d     = phase_q;
        end
      end
      default: page_d = PG_INFO;
    endcase
  end

  // Stage 2: build digit contents of the selected page from the snapshot, blank upper digits.
  always_comb begin
    digits_lo = 16'h0000;
    case (page_d)
      PG_INFO: digits_lo = {snap_q.round, snap_q.win, snap_q.lose, 4'h0};
      PG_P1:   digits_lo = {4'h1, 4'h0, snap_q.p1_black, snap_q.p1_white};
      PG_P2:   digits_lo = {4'h2, 4'h0, snap_q.p2_black, snap_q.p2_white};
      default: digits_lo = {4'hE, 2'b00, snap_q.gameresult, 4'hE, 2'b00, snap_q.matchresult};
    endcase
    blank_d = (state_q == ST_MATCH) && phase_d;
    out_d   = '1;
    if (!blank_d) begin
      out_d[15:0] = digits_lo;
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q       <= '0;
      state_q      <= ST_IDLE;
      state_prev_q <= ST_IDLE;
      page_q       <= PG_INFO;
      hold_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      out_q        <= '1;
      blank_q      <= 1'b1;
    end else begin
      snap_q       <= snap_d;
      state_q      <= state_d;
      state_prev_q <= state_prev_d;
      page_q       <= page_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      out_q        <= out_d;
      blank_q      <= blank_d;
    end
  end

  assign out   = out_q;
  assign page  = page_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_display_page_sequencer.sv
// Testbench for display_page_sequencer: two instances (4 and 6 digits) share all inputs.
// Expected out/blank/page per cycle are queued when stimulus is applied, then popped and compared.
module tb_display_page_sequencer;

  logic        clk;
  logic        reset;
  logic [2:0]  state;
  logic        snap_en;
  logic [3:0]  round, win, lose, p1_black, p1_white, p2_black, p2_white;
  logic [1:0]  gameresult, matchresult;
  logic [15:0] out4;
  logic [23:0] out6;
  logic [1:0]  page4, page6;
  logic        blank4, blank6;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] o;
    logic        b;
    logic [1:0]  p;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [45:0] got, expv;

  display_page_sequencer #(.DIGITS(4), .HOLD_CYCLES(4), .BLINK_CYCLES(3)) u4 (
    .clk(clk), .reset(reset), .state(state), .snap_en(snap_en),
    .round(round), .win(win), .lose(lose),
    .p1_black(p1_black), .p1_white(p1_white), .p2_black(p2_black), .p2_white(p2_white),
    .gameresult(gameresult), .matchresult(matchresult),
    .out(out4), .page(page4), .blank(blank4)
  );

  display_page_sequencer #(.DIGITS(6), .HOLD_CYCLES(4), .BLINK_CYCLES(3)) u6 (
    .clk(clk), .reset(reset), .state(state), .snap_en(snap_en),
    .round(round), .win(win), .lose(lose),
    .p1_black(p1_black), .p1_white(p1_white), .p2_black(p2_black), .p2_white(p2_white),
    .gameresult(gameresult), .matchresult(matchresult),
    .out(out6), .page(page6), .blank(blank6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] o, input logic b, input logic [1:0] p);
    exp_t x;
    x.o = o;
    x.b = b;
    x.p = p;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset = 1'b1; state = 3'd0; snap_en = 1'b0;
    round = 0; win = 0; lose = 0; p1_black = 0; p1_white = 0; p2_black = 0; p2_white = 0;
    gameresult = 0; matchresult = 0;
    for (int i = 1; i <= 3; i++) push(16'hFFFF, 1'b1, 2'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      e = sb.pop_front();
      got  = {out6, out4, blank4, blank6, page4, page6};
      expv = {8'hFF, e.o, e.o, e.b, e.b, e.p, e.p};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, got, expv);
      end
    end
    reset = 1'b0; snap_en = 1'b1; round = 4'd2; win = 4'd13; lose = 4'd10;
    push(16'h0000, 1'b0, 2'd0);
    push(16'h2DA0, 1'b0, 2'd0);
    for (int i = 1; i <= 2; i++) begin
      tick();
      e = sb.pop_front();
      got  = {out6, out4, blank4, blank6, page4, page6};
      expv = {8'hFF, e.o, e.o, e.b, e.b, e.p, e.p};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL static_info cyc=%0d got=%h exp=%h", i, got, expv);
      end
      snap_en = 1'b0;
    end
  endtask

  task automatic test_player();
    state = 3'd1; snap_en = 1'b1; p1_black = 4'd2; p1_white = 4'd3;
    push(16'h2DA0, 1'b0, 2'd0);
    push(16'h1023, 1'b0, 2'd1);
    push(16'h1023, 1'b0, 2'd1);
    push(16'h2010, 1'b0, 2'd2);
    for (int i = 1; i <= 4; i++) begin
      tick();
      e = sb.pop_front();
      got  = {out6, out4, blank4, blank6, page4, page6};
      expv = {8'hFF, e.o, e.o, e.b, e.b, e.p, e.p};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL player cyc=%0d got=%h exp=%h", i, got, expv);
      end
      snap_en = 1'b0;
      if (i == 2) begin
        state = 3'd2; snap_en = 1'b1; p2_black = 4'd1; p2_white = 4'd0;
      end
    end
  endtask

  task automatic test_rotation();
    state = 3'd3; snap_en = 1'b1; gameresult = 2'd2; matchresult = 2'd1;
    push(16'h2010, 1'b0, 2'd2);
    for (int i = 2; i <= 21; i++) begin
      if (i <= 5)       push(16'hE2E1, 1'b0, 2'd3);
      else if (i <= 9)  push(16'h1023, 1'b0, 2'd1);
      else if (i <= 13) push(16'h2010, 1'b0, 2'd2);
      else if (i <= 17) push(16'hE1E1, 1'b0, 2'd3);
      else              push(16'h1023, 1'b0, 2'd1);
    end
    for (int i = 1; i <= 21; i++) begin
      tick();
      e = sb.pop_front();
      got  = {out6, out4, blank4, blank6, page4, page6};
      expv = {8'hFF, e.o, e.o, e.b, e.b, e.p, e.p};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL rotation cyc=%0d got=%h exp=%h", i, got, expv);
      end
      snap_en = (i == 7);
      if (i == 7) gameresult = 2'd1;
    end
  endtask

  task automatic test_blink();
    state = 3'd4; snap_en = 1'b1; gameresult = 2'd2;
    push(16'h2010, 1'b0, 2'd2);
    for (int j = 2; j <= 13; j++) begin
      if (((j - 2) / 3) % 2 == 0) push(16'hE2E1, 1'b0, 2'd3);
      else                        push(16'hFFFF, 1'b1, 2'd3);
    end
    push(16'h1023, 1'b0, 2'd1);
    push(16'h1023, 1'b0, 2'd1);
    for (int j = 1; j <= 15; j++) begin
      tick();
      e = sb.pop_front();
      got  = {out6, out4, blank4, blank6, page4, page6};
      expv = {8'hFF, e.o, e.o, e.b, e.b, e.p, e.p};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL blink cyc=%0d got=%h exp=%h", j, got, expv);
      end
      snap_en = 1'b0;
      if (j == 12) state = 3'd1;
    end
  endtask

  task automatic test_back_to_back();
    state = 3'd3;
    push(16'h1023, 1'b0, 2'd1);
    for (int k = 2; k <= 8; k++) push(16'hE2E1, 1'b0, 2'd3);
    for (int k = 9; k <= 11; k++) push(16'hFFFF, 1'b1, 2'd3);
    for (int k = 12; k <= 15; k++) push(16'hE2E1, 1'b0, 2'd3);
    push(16'hFFFF, 1'b1, 2'd0);
    push(16'h0000, 1'b0, 2'd0);
    for (int k = 18; k <= 21; k++) push(16'hE0E0, 1'b0, 2'd3);
    push(16'h1000, 1'b0, 2'd1);
    for (int k = 1; k <= 22; k++) begin
      tick();
      e = sb.pop_front();
      got  = {out6, out4, blank4, blank6, page4, page6};
      expv = {8'hFF, e.o, e.o, e.b, e.b, e.p, e.p};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", k, got, expv);
      end
      if (k == 4)  state = 3'd4;
      if (k == 11) state = 3'd3;
      reset = (k == 15);
    end
  endtask

  task automatic test_width();
    reset = 1'b1; state = 3'd0;
    push(16'hFFFF, 1'b1, 2'd0);
    push(16'hFFFF, 1'b1, 2'd0);
    push(16'h0000, 1'b0, 2'd0);
    push(16'h2DA0, 1'b0, 2'd0);
    for (int i = 5; i <= 9; i++) push(16'h2DA0, 1'b0, 2'd0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      e = sb.pop_front();
      got  = {out6, out4, blank4, blank6, page4, page6};
      expv = {8'hFF, e.o, e.o, e.b, e.b, e.p, e.p};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL width cyc=%0d got=%h exp=%h", i, got, expv);
      end
      snap_en = 1'b0;
      if (i == 2) begin
        reset = 1'b0; snap_en = 1'b1; round = 4'd2; win = 4'd13; lose = 4'd10;
      end
      if (i == 4) state = 3'd7;
    end
  endtask

  initial begin
    test_reset();
    test_player();
    test_rotation();
    test_blink();
    test_back_to_back();
    test_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
